// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request, ALU and response bundle for the shared-ALU arbiter
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             alu_sign;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_sign;

    logic             busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output alu_op, alu_a, alu_b,
        input  alu_result, alu_zero, alu_sign,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_sign,
        input  rsp0_ready, rsp1_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  alu_op, alu_a, alu_b,
        output alu_result, alu_zero, alu_sign,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_sign,
        output rsp0_ready, rsp1_ready,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one external combinational ALU between two ports
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             owner;
    logic             last_grant;
    logic             grant;
    logic             accept;
    logic             req0_ready;
    logic             req1_ready;
    logic             rsp0_valid;
    logic             rsp1_valid;
    logic             rsp_taken;

    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             rsp_sign;

    // On a tie the port that did not win last time is served.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        accept     = 1'b0;
        rsp_taken  = 1'b0;
        case (state)
            IDLE: begin
                // rst gating keeps ready low while reset is held with a valid request
                req0_ready = !rst && bus.req0_valid && (grant == 1'b0);
                req1_ready = !rst && bus.req1_valid && (grant == 1'b1);
                accept     = req0_ready || req1_ready;
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                rsp0_valid = (owner == 1'b0);
                rsp1_valid = (owner == 1'b1);
                rsp_taken  = owner ? bus.rsp1_ready : bus.rsp0_ready;
                if (rsp_taken) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            alu_op     <= 3'd0;
            alu_a      <= '0;
            alu_b      <= '0;
        end else if (accept) begin
            owner      <= grant;
            last_grant <= grant;
            alu_op     <= grant ? bus.req1_op : bus.req0_op;
            alu_a      <= grant ? bus.req1_a  : bus.req0_a;
            alu_b      <= grant ? bus.req1_b  : bus.req0_b;
        end
    end

    // ALU outputs are captured once, in EXEC, and held through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_sign   <= 1'b0;
        end else if (state == EXEC) begin
            rsp_result <= bus.alu_result;
            rsp_zero   <= bus.alu_zero;
            rsp_sign   <= bus.alu_sign;
        end
    end

    assign bus.req0_ready = req0_ready;
    assign bus.req1_ready = req1_ready;
    assign bus.alu_op     = alu_op;
    assign bus.alu_a      = alu_a;
    assign bus.alu_b      = alu_b;
    assign bus.rsp0_valid = rsp0_valid;
    assign bus.rsp1_valid = rsp1_valid;
    assign bus.rsp_result = rsp_result;
    assign bus.rsp_zero   = rsp_zero;
    assign bus.rsp_sign   = rsp_sign;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed bench for alu_arbiter with a transaction-level reference model
module tb_alu_arbiter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   cmp_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(W)) bus();
    alu_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a ^ b;
            3'b011:  return a | b;
            3'b110:  return a & b;
            default: return '0;
        endcase
    endfunction

    assign bus.alu_result = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
    assign bus.alu_zero   = (bus.alu_result == '0);
    assign bus.alu_sign   = bus.alu_result[W-1];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one outstanding job at most; age 0 = being computed, age 1 = waiting for pickup.
    bit             m_pend;
    int             m_age;
    bit             m_owner;
    bit             m_last;
    logic [2:0]     m_op;
    logic [W-1:0]   m_a, m_b, m_res;
    logic           m_z, m_s;
    logic           e_rdy0, e_rdy1;

    assign e_rdy0 = !rst && !m_pend && bus.req0_valid && (!bus.req1_valid || m_last);
    assign e_rdy1 = !rst && !m_pend && bus.req1_valid && (!bus.req0_valid || !m_last);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend <= 0; m_age <= 0; m_owner <= 0; m_last <= 1;
            m_op <= 0; m_a <= 0; m_b <= 0; m_res <= 0; m_z <= 0; m_s <= 0;
        end else if (!m_pend) begin
            if (e_rdy0 || e_rdy1) begin
                m_pend  <= 1;
                m_age   <= 0;
                m_owner <= e_rdy1;
                m_last  <= e_rdy1;
                m_op    <= e_rdy1 ? bus.req1_op : bus.req0_op;
                m_a     <= e_rdy1 ? bus.req1_a  : bus.req0_a;
                m_b     <= e_rdy1 ? bus.req1_b  : bus.req0_b;
            end
        end else if (m_age == 0) begin
            m_age <= 1;
            m_res <= alu_fn(m_op, m_a, m_b);
            m_z   <= (alu_fn(m_op, m_a, m_b) == '0);
            m_s   <= alu_fn(m_op, m_a, m_b) >> (W - 1);
        end else if (m_owner ? bus.rsp1_ready : bus.rsp0_ready) begin
            m_pend <= 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req0_ready", bus.req0_ready, e_rdy0);
            chk("req1_ready", bus.req1_ready, e_rdy1);
            chk("busy",       bus.busy,       m_pend);
            chk("rsp0_valid", bus.rsp0_valid, m_pend && m_age == 1 && !m_owner);
            chk("rsp1_valid", bus.rsp1_valid, m_pend && m_age == 1 && m_owner);
            chk("alu_op",     bus.alu_op,     m_op);
            chk("alu_a",      bus.alu_a,      m_a);
            chk("alu_b",      bus.alu_b,      m_b);
            chk("rsp_result", bus.rsp_result, m_res);
            chk("rsp_zero",   bus.rsp_zero,   m_z);
            chk("rsp_sign",   bus.rsp_sign,   m_s);
        end
    end

    task automatic set_req0(input logic v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    endtask

    task automatic set_req1(input logic v, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    int grants[$];

    initial begin
        set_req0(0, 3'd0, '0, '0);
        set_req1(0, 3'd0, '0, '0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;

        // Reset, then idle with no requests
        repeat (2) step();
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("t1_busy", bus.busy, 0);
        chk("t1_ready", {bus.req0_ready, bus.req1_ready}, 0);
        chk("t1_rsp", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp_zero, bus.rsp_sign}, 0);
        chk("t1_result", bus.rsp_result, 0);

        // Single port 0 add, latency pinned cycle by cycle
        step();
        set_req0(1, 3'b000, 32'd5, 32'd7);
        @(negedge clk);
        chk("t2_c0_ready", bus.req0_ready, 1);
        step();
        set_req0(0, 3'b000, 32'd5, 32'd7);
        @(negedge clk);
        chk("t2_c1_alu_a", bus.alu_a, 32'd5);
        chk("t2_c1_alu_b", bus.alu_b, 32'd7);
        chk("t2_c1_rsp0", bus.rsp0_valid, 0);
        @(negedge clk);
        chk("t2_c2_rsp0", bus.rsp0_valid, 1);
        chk("t2_c2_result", bus.rsp_result, 32'd12);
        chk("t2_c2_zero", bus.rsp_zero, 0);
        @(negedge clk);
        chk("t2_c3_busy", bus.busy, 0);

        // Port 0 subtract going negative
        step();
        set_req0(1, 3'b001, 32'd1, 32'd2);
        step();
        set_req0(0, 3'b000, '0, '0);
        @(negedge clk);
        @(negedge clk);
        chk("t6_rsp0", bus.rsp0_valid, 1);
        chk("t6_result", bus.rsp_result, 32'hFFFF_FFFF);
        chk("t6_sign", bus.rsp_sign, 1);
        chk("t6_zero", bus.rsp_zero, 0);

        // Port 1 response back-pressured; port 0 waits
        step();
        bus.rsp1_ready = 1'b0;
        set_req1(1, 3'b110, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        chk("t4_req1_ready", bus.req1_ready, 1);
        step();
        set_req1(0, 3'b000, '0, '0);
        set_req0(1, 3'b000, 32'd10, 32'd20);
        @(negedge clk);
        chk("t4_exec_req0_ready", bus.req0_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_hold_rsp1", bus.rsp1_valid, 1);
            chk("t4_hold_result", bus.rsp_result, 32'd1);
            chk("t4_hold_req0_ready", bus.req0_ready, 0);
        end
        step();
        bus.rsp1_ready = 1'b1;
        @(negedge clk);
        chk("t4_hs_req0_ready", bus.req0_ready, 0);
        step();
        @(negedge clk);
        chk("t4_after_req0_ready", bus.req0_ready, 1);
        step();
        set_req0(0, 3'b000, '0, '0);
        repeat (3) step();

        // Reset during EXEC drops the job
        set_req0(1, 3'b000, 32'd1, 32'd1);
        step();
        set_req0(0, 3'b000, '0, '0);
        #1 rst = 1'b1;
        #1;
        chk("t5_busy_now", bus.busy, 0);
        chk("t5_alu_a_now", bus.alu_a, 0);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_rsp0", bus.rsp0_valid, 0);
        end

        // Both ports continuously valid: grants must alternate starting at port 0
        step();
        set_req0(1, 3'b001, 32'd3, 32'd3);
        set_req1(1, 3'b011, 32'hF0, 32'h0F);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.req0_ready) grants.push_back(0);
            if (bus.req1_ready) grants.push_back(1);
            if (bus.rsp0_valid) begin
                chk("t3_rsp0_result", bus.rsp_result, 0);
                chk("t3_rsp0_zero", bus.rsp_zero, 1);
            end
            if (bus.rsp1_valid) chk("t3_rsp1_result", bus.rsp_result, 32'hFF);
        end
        step();
        set_req0(0, 3'b000, '0, '0);
        set_req1(0, 3'b000, '0, '0);
        chk("t3_grant_count", grants.size(), 4);
        for (int i = 0; i < grants.size() && i < 4; i++) begin
            chk("t3_grant_order", grants[i], i % 2);
        end
        repeat (4) step();

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Arbitrates one shared 32-bit ALU between two requesters, e.g. the execute stage (port 0) and an auxiliary unit such as branch-target or address generation (port 1). Uses round-robin grant with valid/ready handshakes on both the request and response sides. Operands are registered before they reach the ALU, and the ALU outputs are registered before the response is returned. The ALU itself stays combinational and sits outside this block.

Parameters:
WIDTH, 32, data width of operands and result.

Ports:
CLK  input  1  clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
req0_valid  input  1  port 0 has a request.
req0_ready  output  1  port 0 request accepted this cycle.
req0_op  input  3  port 0 ALU operation code.
req0_a  input  WIDTH  port 0 operand A.
req0_b  input  WIDTH  port 0 operand B.
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as port 0, for port 1.
alu_op  output  3  registered op code driven to the ALU.
alu_a  output  WIDTH  registered operand A to the ALU.
alu_b  output  WIDTH  registered operand B to the ALU.
alu_result  input  WIDTH  ALU result.
alu_zero  input  1  ALU zero flag.
alu_sign  input  1  ALU sign flag.
rsp0_valid  output  1  response for port 0 is available.
rsp0_ready  input  1  port 0 accepts the response.
rsp1_valid  output  1  response for port 1 is available.
rsp1_ready  input  1  port 1 accepts the response.
rsp_result  output  WIDTH  registered result, shared by both ports.
rsp_zero  output  1  registered zero flag.
rsp_sign  output  1  registered sign flag.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Internal registers:
  - owner (1 bit): port currently being served.
  - last_grant (1 bit): port granted most recently.
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, owner = 0, last_grant = 1 (so port 0 wins the first tie).
  - alu_op/alu_a/alu_b = 0; rsp_result = 0, rsp_zero = 0, rsp_sign = 0.
  - All valid/ready outputs = 0, busy = 0.
- Grant (combinational, evaluated in IDLE only):
  - Only one reqN_valid high: grant that port.
  - Both high: grant the port that is not last_grant.
  - reqN_ready = (state == IDLE) && reqN_valid && (grant == N). At most one ready is high at a time.
- Handshake rules:
  - Requesters must not make reqN_valid depend on reqN_ready.
  - Requesters hold op/a/b stable while valid is high and ready is low.
- IDLE:
  - On accept: latch op/a/b into the alu_* registers; owner = grant; last_grant = grant; state goes to EXEC.
  - With no valid request, state stays IDLE.
- EXEC (exactly 1 cycle): capture alu_result/alu_zero/alu_sign into the rsp_* registers; state goes to RESP.
- RESP:
  - rsp{owner}_valid = 1; the other port's rsp valid = 0.
  - rsp_result/rsp_zero/rsp_sign are held stable until rsp{owner}_ready = 1 is sampled.
  - On that handshake, state goes to IDLE.
  - No request is accepted in RESP or EXEC.
- Latency and throughput:
  - Accept at edge of cycle N; rspN_valid is high during cycle N+2.
  - With rsp ready tied high, the block sustains one operation per 3 cycles.
- alu_op/alu_a/alu_b keep the last accepted values outside EXEC. They change only on accept.
- Op codes are passed through unmodified; this block does not decode or check them.
- Response flags are exactly as the ALU produced them.
- Reset asserted mid-operation (EXEC or RESP): the operation is dropped and no response is produced after reset is released.
- A requester whose valid stays high without being granted keeps waiting. Round-robin guarantees a grant within one service slot.

Test Plan:
1. Assert Reset, then release it with no requests -> all outputs 0, busy = 0, both req ready low.
2. req0: op 000, a = 5, b = 7, held until accepted; rsp0_ready = 1 -> req0_ready high at cycle 0, alu_a = 5 and alu_b = 7 from cycle 1, rsp0_valid at cycle 2 with rsp_result = 12 and zero = 0, back to IDLE at cycle 3.
3. Both ports continuously valid; port 0 op 001 with 3,3; port 1 op 011 with 0xF0,0x0F -> grants alternate 0,1,0,1; port 0 responses give result 0 with zero = 1; port 1 responses give 0xFF.
4. req1: op 110, a = 0xFFFFFFFF, b = 1; rsp1_ready held low for 4 cycles -> rsp1_valid held, rsp_result = 1 stable throughout, req0_ready low throughout even with req0_valid high; port 0 is accepted the cycle after the rsp1 handshake completes.
5. Reset pulsed during EXEC of a port-0 request -> outputs return to 0 immediately, no rsp0_valid afterwards, next tie is granted to port 0.
6. Single req0 with op 001, a = 1, b = 2 -> rsp_result = 0xFFFFFFFF, rsp_sign = 1, rsp_zero = 0.
